// File: rtl/wb_io_arbiter.sv
// wb_io_arbiter: two-master Wishbone arbiter onto the shared IO bus.
// Master 0 is the CPU IO port, master 1 is the wavesynth sequencer.
// A master keeps the bus for as long as it holds cyc. Simultaneous
// requests from IDLE are settled round-robin. At least one IDLE cycle
// always separates two owners.
// Optional feature: define WB_IO_ARB_TIMEOUT_EN to add a slave-response
// watchdog. The watchdog ends a stalled strobe with err to the owner after
// TMO_CYCLES cycles.
module wb_io_arbiter #(
    parameter logic [15:0] TMO_CYCLES = 16'd1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    // master 0 (CPU IO port)
    input  logic [31:0] wbm0_adr_i,
    input  logic [31:0] wbm0_dat_i,
    input  logic [3:0]  wbm0_sel_i,
    input  logic        wbm0_we_i,
    input  logic        wbm0_cyc_i,
    input  logic        wbm0_stb_i,
    input  logic [2:0]  wbm0_cti_i,
    input  logic [1:0]  wbm0_bte_i,
    output logic [31:0] wbm0_dat_o,
    output logic        wbm0_ack_o,
    output logic        wbm0_err_o,
    output logic        wbm0_rty_o,
    // master 1 (wavesynth sequencer)
    input  logic [31:0] wbm1_adr_i,
    input  logic [31:0] wbm1_dat_i,
    input  logic [3:0]  wbm1_sel_i,
    input  logic        wbm1_we_i,
    input  logic        wbm1_cyc_i,
    input  logic        wbm1_stb_i,
    input  logic [2:0]  wbm1_cti_i,
    input  logic [1:0]  wbm1_bte_i,
    output logic [31:0] wbm1_dat_o,
    output logic        wbm1_ack_o,
    output logic        wbm1_err_o,
    output logic        wbm1_rty_o,
    // shared slave side
    output logic [31:0] wbs_adr_o,
    output logic [31:0] wbs_dat_o,
    output logic [3:0]  wbs_sel_o,
    output logic        wbs_we_o,
    output logic        wbs_cyc_o,
    output logic        wbs_stb_o,
    output logic [2:0]  wbs_cti_o,
    output logic [1:0]  wbs_bte_o,
    input  logic [31:0] wbs_dat_i,
    input  logic        wbs_ack_i,
    input  logic        wbs_err_i,
    input  logic        wbs_rty_i,
    output logic [1:0]  grant_o
);

    // Elaboration-time guard on the timeout range.
    if (TMO_CYCLES < 16'd2) begin : g_bad_tmo
        $error("wb_io_arbiter: TMO_CYCLES must be in 2..65535");
    end

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e state_q, state_d;
    logic   last_owner_q, last_owner_d;

    logic   own0, own1;
    logic   req_stb;    // owner's strobe before any timeout masking
    logic   resp_any;
    logic   tmo_fire;

    assign own0     = (state_q == StOwn0);
    assign own1     = (state_q == StOwn1);
    assign resp_any = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign grant_o  = {own1, own0};

    // Next-state: round-robin pick from IDLE, hold while owner keeps cyc.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            StIdle: begin
                if (wbm0_cyc_i && wbm1_cyc_i) begin
                    // The master that was not served last wins the tie.
                    state_d = last_owner_q ? StOwn0 : StOwn1;
                end else if (wbm0_cyc_i) begin
                    state_d = StOwn0;
                end else if (wbm1_cyc_i) begin
                    state_d = StOwn1;
                end
            end
            StOwn0: begin
                if (!wbm0_cyc_i) begin
                    state_d      = StIdle;
                    last_owner_d = 1'b0;
                end
            end
            StOwn1: begin
                if (!wbm1_cyc_i) begin
                    state_d      = StIdle;
                    last_owner_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and round-robin history registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Request mux: route the owner's qualifiers to the slave bus, zero in IDLE.
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        req_stb   = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        if (own0) begin
            wbs_adr_o = wbm0_adr_i;
            wbs_dat_o = wbm0_dat_i;
            wbs_sel_o = wbm0_sel_i;
            wbs_we_o  = wbm0_we_i;
            wbs_cyc_o = wbm0_cyc_i;
            req_stb   = wbm0_stb_i;
            wbs_cti_o = wbm0_cti_i;
            wbs_bte_o = wbm0_bte_i;
        end else if (own1) begin
            wbs_adr_o = wbm1_adr_i;
            wbs_dat_o = wbm1_dat_i;
            wbs_sel_o = wbm1_sel_i;
            wbs_we_o  = wbm1_we_i;
            wbs_cyc_o = wbm1_cyc_i;
            req_stb   = wbm1_stb_i;
            wbs_cti_o = wbm1_cti_i;
            wbs_bte_o = wbm1_bte_i;
        end
        wbs_stb_o = req_stb & ~tmo_fire;
    end

    // Response demux: only the owner sees the slave; IDLE responses are dropped.
    always_comb begin
        wbm0_dat_o = own0 ? wbs_dat_i : 32'h0;
        wbm0_ack_o = own0 & wbs_ack_i;
        wbm0_err_o = own0 & (wbs_err_i | tmo_fire);
        wbm0_rty_o = own0 & wbs_rty_i;
        wbm1_dat_o = own1 ? wbs_dat_i : 32'h0;
        wbm1_ack_o = own1 & wbs_ack_i;
        wbm1_err_o = own1 & (wbs_err_i | tmo_fire);
        wbm1_rty_o = own1 & wbs_rty_i;
    end

`ifdef WB_IO_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    // A real slave response in the expiry cycle takes priority over the timeout.
    assign tmo_fire = req_stb & ~resp_any & (tmo_cnt_q == TMO_CYCLES - 16'd1);

    // Count stalled strobe cycles; any gap, response or expiry restarts it.
    always_comb begin
        tmo_cnt_d = '0;
        if (wbs_stb_o && !resp_any) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_resp;
    assign unused_resp = resp_any;
    assign tmo_fire    = 1'b0;
`endif

endmodule

// File: tb/tb_wb_io_arbiter.sv
// Bench for wb_io_arbiter: directed scenarios followed by a random phase.
// Every cycle is compared against an owner/history reference model.
module tb_wb_io_arbiter;

    localparam logic [15:0] TMO = 16'd8;
`ifdef WB_IO_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic        m_we  [2];
    logic        m_cyc [2];
    logic        m_stb [2];
    logic [2:0]  m_cti [2];
    logic [1:0]  m_bte [2];
    logic [31:0] m_dato [2];
    logic        m_ack [2];
    logic        m_err [2];
    logic        m_rty [2];

    logic [31:0] wbs_adr, wbs_dat;
    logic [3:0]  wbs_sel;
    logic        wbs_we, wbs_cyc, wbs_stb;
    logic [2:0]  wbs_cti;
    logic [1:0]  wbs_bte;
    logic [31:0] s_dat;
    logic        s_ack, s_err, s_rty;
    logic [1:0]  grant;

    wb_io_arbiter #(.TMO_CYCLES(TMO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbm0_adr_i (m_adr[0]),
        .wbm0_dat_i (m_dat[0]),
        .wbm0_sel_i (m_sel[0]),
        .wbm0_we_i  (m_we[0]),
        .wbm0_cyc_i (m_cyc[0]),
        .wbm0_stb_i (m_stb[0]),
        .wbm0_cti_i (m_cti[0]),
        .wbm0_bte_i (m_bte[0]),
        .wbm0_dat_o (m_dato[0]),
        .wbm0_ack_o (m_ack[0]),
        .wbm0_err_o (m_err[0]),
        .wbm0_rty_o (m_rty[0]),
        .wbm1_adr_i (m_adr[1]),
        .wbm1_dat_i (m_dat[1]),
        .wbm1_sel_i (m_sel[1]),
        .wbm1_we_i  (m_we[1]),
        .wbm1_cyc_i (m_cyc[1]),
        .wbm1_stb_i (m_stb[1]),
        .wbm1_cti_i (m_cti[1]),
        .wbm1_bte_i (m_bte[1]),
        .wbm1_dat_o (m_dato[1]),
        .wbm1_ack_o (m_ack[1]),
        .wbm1_err_o (m_err[1]),
        .wbm1_rty_o (m_rty[1]),
        .wbs_adr_o  (wbs_adr),
        .wbs_dat_o  (wbs_dat),
        .wbs_sel_o  (wbs_sel),
        .wbs_we_o   (wbs_we),
        .wbs_cyc_o  (wbs_cyc),
        .wbs_stb_o  (wbs_stb),
        .wbs_cti_o  (wbs_cti),
        .wbs_bte_o  (wbs_bte),
        .wbs_dat_i  (s_dat),
        .wbs_ack_i  (s_ack),
        .wbs_err_i  (s_err),
        .wbs_rty_i  (s_rty),
        .grant_o    (grant)
    );

    // Reference model: who owns the bus (-1 = nobody), who was served last,
    // and how many consecutive cycles the owner's strobe has gone unanswered.
    int owner;
    int last;
    int stall;
    int checks;
    int failures;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_fire();
        if (!TMO_EN || owner < 0) return 1'b0;
        return m_stb[owner] && !(s_ack || s_err || s_rty) && (stall == int'(TMO) - 1);
    endfunction

    task automatic compare_all();
        bit          fire;
        logic [1:0]  g;
        logic [31:0] e_adr, e_dat;
        logic [11:0] e_ctl;
        fire  = model_fire();
        g     = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        e_adr = '0;
        e_dat = '0;
        e_ctl = '0;
        if (owner >= 0) begin
            e_adr = m_adr[owner];
            e_dat = m_dat[owner];
            e_ctl = {m_sel[owner], m_we[owner], m_cyc[owner], m_stb[owner] & ~fire,
                     m_cti[owner], m_bte[owner]};
        end
        check("grant", grant, g);
        check("wbs_adr", wbs_adr, e_adr);
        check("wbs_dat", wbs_dat, e_dat);
        check("wbs_ctl", {wbs_sel, wbs_we, wbs_cyc, wbs_stb, wbs_cti, wbs_bte}, e_ctl);
        for (int n = 0; n < 2; n++) begin
            logic [34:0] e_rsp;
            e_rsp = '0;
            if (owner == n) e_rsp = {s_dat, s_ack, s_err | fire, s_rty};
            check(n == 0 ? "m0_resp" : "m1_resp", {m_dato[n], m_ack[n], m_err[n], m_rty[n]},
                  e_rsp);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        last  = 1;
        stall = 0;
    endtask

    task automatic model_edge();
        bit fire;
        if (!rst_n) begin
            model_reset();
            return;
        end
        fire = model_fire();
        if (owner >= 0 && m_stb[owner] && !(s_ack || s_err || s_rty) && !fire) stall++;
        else stall = 0;
        if (owner < 0) begin
            if (m_cyc[0] && m_cyc[1]) owner = (last == 0) ? 1 : 0;
            else if (m_cyc[0]) owner = 0;
            else if (m_cyc[1]) owner = 1;
        end else if (!m_cyc[owner]) begin
            last  = owner;
            owner = -1;
        end
    endtask

    // Compare mid-cycle, then advance one rising edge; returns 1 time unit after it.
    task automatic tick();
        #2;
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_m(input int n, input bit cyc, input bit stb, input logic [2:0] cti);
        m_adr[n] = $urandom;
        m_dat[n] = $urandom;
        m_sel[n] = 4'($urandom);
        m_we[n]  = 1'($urandom);
        m_cyc[n] = cyc;
        m_stb[n] = stb;
        m_cti[n] = cti;
        m_bte[n] = 2'($urandom);
    endtask

    task automatic set_s(input bit ack, input bit err, input bit rty);
        s_ack = ack;
        s_err = err;
        s_rty = rty;
        s_dat = $urandom;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        rst_n = 1'b0;
        set_m(0, 1'b1, 1'b1, 3'b000);
        set_m(1, 1'b1, 1'b1, 3'b000);
        set_s(1'b1, 1'b1, 1'b1);
        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_m_ack", {m_ack[0], m_err[0], m_rty[0], m_ack[1], m_err[1], m_rty[1]}, 6'b0);
        tick();
        tick();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Tie straight out of reset: master 0 first, one IDLE cycle, then master 1.
        set_s(1'b0, 1'b0, 1'b0);
        tick();
        #1 check("tie_after_reset", grant, 2'b01);
        set_s(1'b1, 1'b0, 1'b0);
        tick();
        set_m(0, 1'b0, 1'b0, 3'b000);
        set_s(1'b0, 1'b0, 1'b0);
        tick();
        #1 check("gap_idle", grant, 2'b00);
        tick();
        #1 check("second_owner", grant, 2'b10);
        set_m(1, 1'b0, 1'b0, 3'b000);
        tick();

        // Round-robin: after master 1 served, tie goes to master 0, and vice versa.
        set_m(0, 1'b1, 1'b1, 3'b000);
        set_m(1, 1'b1, 1'b1, 3'b000);
        tick();
        #1 check("rr_after_m1", grant, 2'b01);
        set_m(0, 1'b0, 1'b0, 3'b000);
        set_m(1, 1'b0, 1'b0, 3'b000);
        tick();
        set_m(0, 1'b1, 1'b1, 3'b000);
        set_m(1, 1'b1, 1'b1, 3'b000);
        tick();
        #1 check("rr_after_m0", grant, 2'b10);
        set_m(0, 1'b0, 1'b0, 3'b000);
        set_m(1, 1'b0, 1'b0, 3'b000);
        tick();

        // Single read by master 0, slave acks on the third owned cycle.
        set_m(0, 1'b1, 1'b1, 3'b000);
        m_adr[0] = 32'h0000_1000;
        m_we[0]  = 1'b0;
        #1 check("rd_grant_latency", grant, 2'b00);
        tick();
        #1 check("rd_grant", {grant, wbs_cyc}, {2'b01, 1'b1});
        tick();
        tick();
        set_s(1'b1, 1'b0, 1'b0);
        s_dat = 32'hDEAD_BEEF;
        #1 check("rd_data", {m_dato[0], m_ack[0], m_ack[1]}, {32'hDEAD_BEEF, 1'b1, 1'b0});
        tick();
        set_m(0, 1'b0, 1'b0, 3'b000);
        set_s(1'b0, 1'b0, 1'b0);
        tick();

        // Master 1 4-beat burst while master 0 waits with cyc high.
        set_m(1, 1'b1, 1'b1, 3'b010);
        tick();
        set_m(0, 1'b1, 1'b1, 3'b000);
        for (int b = 0; b < 4; b++) begin
            set_m(1, 1'b1, 1'b1, (b < 3) ? 3'b010 : 3'b111);
            set_s(1'b1, 1'b0, 1'b0);
            #1 check("burst_ack", {grant, m_ack[1], m_ack[0]}, {2'b10, 1'b1, 1'b0});
            tick();
        end
        set_m(1, 1'b0, 1'b0, 3'b000);
        set_s(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        #1 check("burst_then_m0", grant, 2'b01);

        // Hung slave: err exactly on the TMO-th stalled strobe cycle when enabled.
        tick();
        for (int i = 0; i < int'(TMO) + 2; i++) begin
            #1 check("tmo_err", m_err[0], TMO_EN && (i == int'(TMO) - 2));
            tick();
        end
        set_m(0, 1'b0, 1'b0, 3'b000);
        tick();
        set_s(1'b1, 1'b1, 1'b1);
        #1 check("idle_resp_drop", {m_ack[0], m_err[0], m_rty[0], m_ack[1], m_err[1],
                                    m_rty[1]}, 6'b0);
        tick();
        set_s(1'b0, 1'b0, 1'b0);

        // Reset pulse in the middle of a master 1 burst.
        set_m(1, 1'b1, 1'b1, 3'b010);
        tick();
        set_s(1'b1, 1'b0, 1'b0);
        tick();
        rst_n = 1'b0;
        model_reset();
        #1 check("midrst_drop", {grant, wbs_cyc, wbs_stb, m_ack[1]}, 5'b0);
        tick();
        rst_n = 1'b1;
        set_s(1'b0, 1'b0, 1'b0);
        set_m(0, 1'b1, 1'b1, 3'b000);
        set_m(1, 1'b1, 1'b1, 3'b000);
        tick();
        #1 check("tie_after_midrst", grant, 2'b01);
        set_m(0, 1'b0, 1'b0, 3'b000);
        set_m(1, 1'b0, 1'b0, 3'b000);
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            for (int n = 0; n < 2; n++) begin
                bit      cyc;
                int      k;
                cyc = m_cyc[n] ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 3) == 0);
                k   = $urandom_range(0, 2);
                set_m(n, cyc, cyc && ($urandom_range(0, 3) != 0),
                      (k == 0) ? 3'b000 : (k == 1) ? 3'b010 : 3'b111);
            end
            begin
                int r;
                r = $urandom_range(0, 11);
                set_s(r < 3, r == 3, r == 4);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_io_arbiter.md
WB_IO_ARBITER -- requirements
Module: wb_io_arbiter

Interface
REQ-001 Parameter TMO_CYCLES, default 16'd1024: slave-response timeout in wb_clk_i cycles (legal range 2..65535).
REQ-002 Port wb_clk_i, input, 1: the single clock, rising-edge.
REQ-003 Port wb_rst_ni, input, 1: reset, asynchronous and active-low.
REQ-004 Ports wbm{0,1}_adr_i and wbm{0,1}_dat_i, input, 32 each: master n address and write data; master 0 is the CPU IO port, master 1 is the wavesynth sequencer.
REQ-005 Ports wbm{0,1}_sel_i (input, 4), wbm{0,1}_we_i/cyc_i/stb_i (input, 1 each), wbm{0,1}_cti_i (input, 3) and wbm{0,1}_bte_i (input, 2): master n cycle qualifiers.
REQ-006 Ports wbm{0,1}_dat_o (output, 32) and wbm{0,1}_ack_o/err_o/rty_o (output, 1 each): master n read data and termination.
REQ-007 Ports wbs_adr_o and wbs_dat_o (output, 32 each), wbs_sel_o (output, 4), wbs_we_o/cyc_o/stb_o (output, 1 each), wbs_cti_o (output, 3) and wbs_bte_o (output, 2): shared IO bus toward the address decoder mux.
REQ-008 Ports wbs_dat_i (input, 32) and wbs_ack_i/err_i/rty_i (input, 1 each): shared bus response.
REQ-009 Port grant_o, output, 2: one-hot current owner; 2'b00 when idle.

Function
REQ-010 FSM states IDLE, OWN0 and OWN1 SHALL be held in a register, with a 1-bit last_owner register.
REQ-011 IDLE: if exactly one wbm{n}_cyc_i is high, the next state SHALL be OWNn.
REQ-012 IDLE: if both cyc are high, the next state SHALL be OWN of the master that is not last_owner (round-robin).
REQ-013 Grant latency SHALL be exactly one cycle: cyc seen in IDLE at edge N gives grant_o and wbs_cyc_o at N+1.
REQ-014 OWNn SHALL persist while wbm{n}_cyc_i is high, including across burst beats (cti 3'b010), independent of the other master.
REQ-015 OWNn -> IDLE SHALL occur on the first edge with wbm{n}_cyc_i low; last_owner<=n on that edge.
REQ-016 No back-to-back regrant: at least one IDLE cycle SHALL occur between owners.
REQ-017 In OWNn, all wbs_* request outputs SHALL combinationally equal master n's inputs.
REQ-018 In IDLE, wbs_cyc_o and wbs_stb_o SHALL be 0 and the other wbs_* outputs SHALL be 0.
REQ-019 Owner ack/err/rty/dat SHALL equal the wbs_* responses; the non-owner SHALL see ack/err/rty=0 and dat_o=0.
REQ-020 A response arriving in IDLE SHALL be dropped and not forwarded.
REQ-021 A master that drops cyc mid-burst SHALL lose the grant per REQ-015; no error is signalled.

Reset
REQ-022 While wb_rst_ni is low: state=IDLE, last_owner=1 (master 0 wins the first tie), timeout counter=0, grant_o=0, all wbs_cyc_o/stb_o=0, all master ack/err/rty=0.
REQ-023 Reset asserted mid-transfer SHALL drop wbs_cyc_o asynchronously, with no termination sent to the master.
REQ-024 Leaving reset, the first grant SHALL follow REQ-011/REQ-012 from the first edge after deassertion.

Configuration
REQ-025 Macro WB_IO_ARB_TIMEOUT_EN defined: a 16-bit counter SHALL clear on grant, on any wbs ack/err/rty, and whenever wbs_stb_o=0; it SHALL increment each cycle that wbs_stb_o=1 with no response.
REQ-026 With WB_IO_ARB_TIMEOUT_EN, when the counter equals TMO_CYCLES-1, the owner's err_o SHALL pulse 1 cycle, the counter SHALL clear, and wbs_stb_o SHALL be forced 0 that cycle.
REQ-027 With WB_IO_ARB_TIMEOUT_EN, a slave ack in the same cycle as the timeout SHALL win: ack is forwarded and no err is generated.
REQ-028 Macro absent: no counter SHALL be present; a hung slave holds the bus indefinitely; behaviour otherwise identical.

Verification
REQ-029 M0 single read of adr 0x00001000, slave acks after 2 cycles with 0xDEADBEEF -> grant_o=01 one cycle after cyc, wbm0_dat_o=0xDEADBEEF with wbm0_ack_o, wbm1_ack_o=0 throughout.
REQ-030 M0 and M1 assert cyc in the same cycle after reset -> M0 granted first; after M0 drops cyc, 1 IDLE cycle then grant_o=10.
REQ-031 Repeat the tie after M1 was served last -> M0 granted; after M0 was served last -> M1 granted.
REQ-032 M1 4-beat burst (cti 010,010,010,111) while M0 holds cyc -> M1 keeps grant for all 4 acks; M0 sees no ack until granted.
REQ-033 Timeout enabled, TMO_CYCLES=8, slave never acks -> err to owner exactly 8 cycles after stb; unrelated ack in IDLE is ignored.
REQ-034 wb_rst_ni pulsed low mid-burst -> wbs_cyc_o=0 immediately, grant_o=00, and the next tie goes to M0.
